// File: rtl/pio_pkg.sv
// Shared definitions for the PIO host command bridge: action codes, frame size, bridge FSM states.
package pio_pkg;

    localparam logic [3:0] ACT_NOP     = 4'd0;
    localparam logic [3:0] ACT_INSTR   = 4'd1;
    localparam logic [3:0] ACT_PEND    = 4'd2;
    localparam logic [3:0] ACT_PULL    = 4'd3;
    localparam logic [3:0] ACT_PUSH    = 4'd4;
    localparam logic [3:0] ACT_PINS    = 4'd5;
    localparam logic [3:0] ACT_EN      = 4'd6;
    localparam logic [3:0] ACT_DIV     = 4'd7;
    localparam logic [3:0] ACT_SIDESET = 4'd8;
    localparam logic [3:0] ACT_IMM     = 4'd9;
    localparam logic [3:0] ACT_JMPPIN  = 4'd10;
    localparam logic [3:0] ACT_READ    = 4'd11;

    localparam int FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_ISSUE,
        ST_TX
    } bridge_state_t;

    // Opcodes that become a one-cycle strobe on the PIO config port.
    function automatic logic is_fwd(input logic [3:0] op);
        return (op >= ACT_INSTR) && (op <= ACT_JMPPIN);
    endfunction

endpackage

// File: rtl/pio_cmd_bridge.sv
// Assembles 6-byte host frames into PIO action strobes; READ frames return pio_dout as 4 TX bytes.
// Strobe one cycle after the last frame byte; TX waits indefinitely on tx_ready, RX stalls while busy issuing/sending.
module pio_cmd_bridge
    import pio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [1:0]  pio_mindex,
    output logic [4:0]  pio_index,
    output logic [31:0] pio_din,
    output logic [3:0]  pio_action,
    input  logic [31:0] pio_dout,
    output logic        busy,
    output logic        frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

    bridge_state_t state, state_nxt;

    logic [3:0]    op_q;
    logic [1:0]    mindex_q;
    logic [4:0]    index_q;
    logic [31:0]   din_q;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   tx_sh;
    logic [1:0]    tx_cnt;
    logic          tmo_hit;

    // In HDR/DATA rx_ready is 1, so rx_valid alone means a transfer this cycle.
    assign tmo_hit = TMO_EN && ((state == ST_HDR) || (state == ST_DATA))
                     && !rx_valid && (tmo_cnt == TMO_LIMIT);

    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        pio_action = ACT_NOP;
        frame_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_nxt = ST_DATA;
                end else if (tmo_hit) begin
                    frame_err = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_nxt = ST_ISSUE;
                end else if (tmo_hit) begin
                    frame_err = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (is_fwd(op_q))        pio_action = op_q;
                else if (op_q > ACT_READ) frame_err = 1'b1;
                state_nxt = (op_q == ACT_READ) ? ST_TX : ST_IDLE;
            end
            ST_TX: begin
                tx_valid = 1'b1;
                if (tx_ready && (tx_cnt == 2'd3)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            rx_ready   = 1'b0;
            tx_valid   = 1'b0;
            pio_action = ACT_NOP;
            frame_err  = 1'b0;
            state_nxt  = ST_IDLE;
        end
    end

    assign busy    = !reset && (state != ST_IDLE);
    assign tx_data = (!reset && (state == ST_TX)) ? tx_sh[7:0] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= ACT_NOP;
            mindex_q   <= '0;
            index_q    <= '0;
            din_q      <= '0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            tx_sh      <= '0;
            tx_cnt     <= '0;
            pio_mindex <= '0;
            pio_index  <= '0;
            pio_din    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (rx_valid) begin
                        op_q     <= rx_data[7:4];
                        mindex_q <= rx_data[3:2];
                    end
                end
                ST_HDR, ST_DATA: begin
                    if (rx_valid) begin
                        tmo_cnt <= '0;
                        if (state == ST_HDR) begin
                            index_q  <= rx_data[4:0];
                            byte_cnt <= '0;
                        end else begin
                            din_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            // Only forwarded commands move the PIO-facing registers.
                            if ((byte_cnt == 2'd3) && is_fwd(op_q)) begin
                                pio_mindex <= mindex_q;
                                pio_index  <= index_q;
                                pio_din    <= {rx_data, din_q[23:0]};
                            end
                        end
                    end else if (tmo_hit) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    if (op_q == ACT_READ) begin
                        tx_sh  <= pio_dout;
                        tx_cnt <= '0;
                    end
                end
                ST_TX: begin
                    if (tx_ready) begin
                        tx_sh  <= {8'h00, tx_sh[31:8]};
                        tx_cnt <= tx_cnt + 2'd1;
                    end
                end
                default: tmo_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Directed bench for pio_cmd_bridge: table of command frames plus hand-written READ, timeout, reset and back-to-back sequences.
module tb_pio_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [1:0]  pio_mindex;
    logic [4:0]  pio_index;
    logic [31:0] pio_din;
    logic [3:0]  pio_action;
    logic [31:0] pio_dout = 32'h0;
    logic        busy;
    logic        frame_err;

    pio_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .pio_mindex(pio_mindex), .pio_index(pio_index), .pio_din(pio_din),
        .pio_action(pio_action), .pio_dout(pio_dout),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int strobe_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (pio_action != 4'd0) begin
        strobes++;
        strobe_cyc.push_back(cyc);
    end

    typedef struct {
        logic [47:0] frame;
        logic [3:0]  act;
        logic [1:0]  mi;
        logic [4:0]  idx;
        logic [31:0] din;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47 - 8*i -: 8]);
    endtask

    initial begin
        int s0, nb, k;
        logic [31:0] exp_w;

        vecs[0] = '{48'h10_05_34_12_CD_AB, 4'd1,  2'd0, 5'd5,  32'hABCD1234, 1'b0};
        vecs[1] = '{48'h6D_3F_01_02_03_04, 4'd6,  2'd3, 5'd31, 32'h04030201, 1'b0};
        vecs[2] = '{48'hA4_E2_FF_00_00_80, 4'd10, 2'd1, 5'd2,  32'h800000FF, 1'b0};
        vecs[3] = '{48'hF0_01_11_22_33_44, 4'd0,  2'd1, 5'd2,  32'h800000FF, 1'b1};
        vecs[4] = '{48'h00_1F_55_55_55_55, 4'd0,  2'd1, 5'd2,  32'h800000FF, 1'b0};
        vecs[5] = '{48'h7B_10_78_56_34_12, 4'd7,  2'd2, 5'd16, 32'h12345678, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_action", 32'(pio_action), 32'd0);
        chk("rst_mindex", 32'(pio_mindex), 32'd0);
        chk("rst_index", 32'(pio_index), 32'd0);
        chk("rst_din", pio_din, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Table of frames: checked in the ISSUE cycle and the cycle after
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].frame);
            chk($sformatf("v%0d_action", v), 32'(pio_action), 32'(vecs[v].act));
            chk($sformatf("v%0d_err", v), 32'(frame_err), 32'(vecs[v].err));
            chk($sformatf("v%0d_mindex", v), 32'(pio_mindex), 32'(vecs[v].mi));
            chk($sformatf("v%0d_index", v), 32'(pio_index), 32'(vecs[v].idx));
            chk($sformatf("v%0d_din", v), pio_din, vecs[v].din);
            chk($sformatf("v%0d_issue_rx_ready", v), 32'(rx_ready), 32'd0);
            chk($sformatf("v%0d_issue_busy", v), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_action_after", v), 32'(pio_action), 32'd0);
            chk($sformatf("v%0d_err_after", v), 32'(frame_err), 32'd0);
            chk($sformatf("v%0d_idle_after", v), 32'(busy), 32'd0);
        end

        // Back-to-back frames with rx_valid never low at a clock edge
        @(negedge clk);
        s0 = strobes;
        strobe_cyc.delete();
        send_frame(48'h20_01_01_00_00_00);
        send_frame(48'h50_02_02_00_00_00);
        repeat (2) @(negedge clk);
        chk("b2b_strobes", 32'(strobes - s0), 32'd2);
        if (strobe_cyc.size() == 2)
            chk("b2b_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd7);
        else
            chk("b2b_queue", 32'(strobe_cyc.size()), 32'd2);

        // READ: tx_valid two cycles after B5, long stall, then toggling tx_ready
        pio_dout = 32'hDEADBEEF;
        exp_w    = 32'hDEADBEEF;
        tx_ready = 1'b0;
        s0 = strobes;
        send_frame(48'hB0_00_00_00_00_00);
        chk("rd_issue_tx_valid", 32'(tx_valid), 32'd0);
        chk("rd_issue_action", 32'(pio_action), 32'd0);
        @(negedge clk);
        chk("rd_tx_valid_first", 32'(tx_valid), 32'd1);
        repeat (40) @(negedge clk);
        chk("rd_stall_tx_valid", 32'(tx_valid), 32'd1);
        chk("rd_stall_tx_data", 32'(tx_data), 32'hEF);
        chk("rd_stall_err", 32'(frame_err), 32'd0);
        nb = 0;
        k = 0;
        while (nb < 4 && k < 64) begin
            chk("rd_rx_ready_low", 32'(rx_ready), 32'd0);
            tx_ready = k[0];
            if (tx_ready && tx_valid) begin
                chk($sformatf("rd_byte%0d", nb), 32'(tx_data), 32'(exp_w[8*nb +: 8]));
                nb++;
            end
            @(negedge clk);
            k++;
        end
        tx_ready = 1'b0;
        chk("rd_byte_count", 32'(nb), 32'd4);
        chk("rd_done_tx_valid", 32'(tx_valid), 32'd0);
        chk("rd_done_rx_ready", 32'(rx_ready), 32'd1);
        chk("rd_no_strobe", 32'(strobes - s0), 32'd0);

        // Timeout: B0,B1 then idle; error exactly 16 cycles after B1
        send_byte(8'h60);
        send_byte(8'h07);
        for (int t = 0; t < 20; t++) begin
            chk($sformatf("tmo_err_c%0d", t), 32'(frame_err), (t == 15) ? 32'd1 : 32'd0);
            if (t == 16) chk("tmo_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        send_frame(48'h60_00_0F_00_00_00);
        chk("tmo_next_action", 32'(pio_action), 32'd6);
        chk("tmo_next_din", pio_din, 32'h0000000F);
        chk("tmo_next_index", 32'(pio_index), 32'd0);
        @(negedge clk);

        // Reset mid-frame (after B3)
        s0 = strobes;
        send_byte(8'h20);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_din", pio_din, 32'd0);
        chk("mid_rst_index", 32'(pio_index), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        send_frame(48'h30_04_01_00_00_00);
        chk("post_rst_action", 32'(pio_action), 32'd3);
        chk("post_rst_index", 32'(pio_index), 32'd4);
        chk("post_rst_din", pio_din, 32'h00000001);
        chk("post_rst_mindex", 32'(pio_mindex), 32'd0);
        repeat (2) @(negedge clk);
        chk("post_rst_strobes", 32'(strobes - s0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
